glyph_row_fetch: RTL and testbench

- Upstream feeder for the VGA character renderer. Runs at 800x600, 50 MHz pixel clock.
- Once per display line, if the line falls inside the glyph box, it reads one 128-bit glyph row from an external synchronous font ROM.
- It then serialises that row MSB-first into a 1-bit-per-pixel stream, aligned to the glyph box's horizontal window.
- This replaces hard-coded per-line row constants in the renderer with a single ROM-backed fetch/shift path.

---
 rtl/glyph_row_fetch.sv | 159 +++++++++++++++
 tb/tb_glyph_row_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_fetch.sv
// Per-line glyph row fetch from a synchronous font ROM, serialised MSB-first
// into a 1-bpp pixel stream aligned to the glyph box's horizontal window.
module glyph_row_fetch #(
  parameter int unsigned ROW_BITS = 128,
  parameter int unsigned ROWS     = 32,
  parameter int unsigned AW       = 5,
  parameter int unsigned Y_ORIGIN = 231,
  parameter int unsigned X_ORIGIN = 301,
  parameter int unsigned ROM_LAT  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                line_start,
  input  logic [8:0]          y_dis,
  input  logic [9:0]          x_dis,
  output logic                rom_rd,
  output logic [AW-1:0]       rom_addr,
  input  logic [ROW_BITS-1:0] rom_data,
  output logic                pix_in_box,
  output logic                pix_on,
  output logic                fetch_err
);

  localparam int unsigned CW = $clog2(ROW_BITS);
  localparam int unsigned LW = 3;
  localparam logic [8:0]  Y_LO = 9'(Y_ORIGIN);
  localparam logic [8:0]  Y_HI = 9'(Y_ORIGIN + ROWS - 1);
  localparam logic [9:0]  X_AT = 10'(X_ORIGIN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_WAIT   = 3'd2,
    S_LOADED = 3'd3,
    S_SHIFT  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [LW-1:0]       lat_cnt_q, lat_cnt_d;
  logic                rom_rd_q, rom_rd_d;
  logic [AW-1:0]       rom_addr_q, rom_addr_d;
  logic                pix_in_box_q, pix_in_box_d;
  logic                pix_on_q, pix_on_d;
  logic                fetch_err_q, fetch_err_d;

  logic y_in_box;
  logic x_hit;
  logic lat_done;

  assign y_in_box = (y_dis >= Y_LO) && (y_dis <= Y_HI);
  assign x_hit    = (x_dis == X_AT);
  assign lat_done = (lat_cnt_q == LW'(1));

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      bit_cnt_q    <= '0;
      lat_cnt_q    <= '0;
      rom_rd_q     <= 1'b0;
      rom_addr_q   <= '0;
      pix_in_box_q <= 1'b0;
      pix_on_q     <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bit_cnt_q    <= bit_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      rom_rd_q     <= rom_rd_d;
      rom_addr_q   <= rom_addr_d;
      pix_in_box_q <= pix_in_box_d;
      pix_on_q     <= pix_on_d;
      fetch_err_q  <= fetch_err_d;
    end
  end

  // Next state; line_start overrides everything else
  always_comb begin
    state_d = state_q;
    if (line_start) begin
      state_d = y_in_box ? S_REQ : S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   state_d = S_IDLE;
        S_REQ:    state_d = x_hit ? S_IDLE : S_WAIT;
        S_WAIT: begin
          if (x_hit)         state_d = S_IDLE;
          else if (lat_done) state_d = S_LOADED;
          else               state_d = S_WAIT;
        end
        S_LOADED: state_d = x_hit ? S_SHIFT : S_LOADED;
        S_SHIFT:  state_d = (bit_cnt_q == '0) ? S_IDLE : S_SHIFT;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    row_d        = row_q;
    bit_cnt_d    = bit_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    rom_addr_d   = rom_addr_q;
    rom_rd_d     = 1'b0;
    pix_in_box_d = 1'b0;
    pix_on_d     = 1'b0;
    fetch_err_d  = 1'b0;
    if (line_start) begin
      if (y_in_box) begin
        rom_addr_d = AW'(y_dis - Y_LO);
        rom_rd_d   = 1'b1;
      end
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (x_hit) fetch_err_d = 1'b1;
          else       lat_cnt_d   = LW'(ROM_LAT);
        end
        S_WAIT: begin
          // Row not yet captured when the window opens: flag and drop the fetch
          if (x_hit) begin
            fetch_err_d = 1'b1;
          end else begin
            lat_cnt_d = lat_cnt_q - LW'(1);
            if (lat_done) row_d = rom_data;
          end
        end
        S_LOADED: begin
          if (x_hit) begin
            pix_in_box_d = 1'b1;
            pix_on_d     = row_q[ROW_BITS-1];
            row_d        = {row_q[ROW_BITS-2:0], 1'b0};
            bit_cnt_d    = CW'(ROW_BITS - 1);
          end
        end
        S_SHIFT: begin
          if (bit_cnt_q != '0) begin
            pix_in_box_d = 1'b1;
            pix_on_d     = row_q[ROW_BITS-1];
            row_d        = {row_q[ROW_BITS-2:0], 1'b0};
            bit_cnt_d    = bit_cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rom_rd     = rom_rd_q;
  assign rom_addr   = rom_addr_q;
  assign pix_in_box = pix_in_box_q;
  assign pix_on     = pix_on_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_glyph_row_fetch.sv
// Directed bench for glyph_row_fetch: a default instance plus a late-ROM,
// early-window instance, each fed by a behavioural font ROM.
module tb_glyph_row_fetch;

  localparam logic [127:0] JUNK     = {4{32'hDEADBEEF}};
  localparam logic [127:0] TOP_ROW  = 128'h80000000_00000000_00000000_00000001;
  localparam logic [127:0] FULL_ROW = 128'h0001C000_03FFFFE0_04000010_01020180;
  localparam logic [127:0] LAST_ROW = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] ONES_ROW = {128{1'b1}};
  localparam logic [127:0] LATE_ROW = 128'hF00F0FF0_A5A5A5A5_00FF00FF_C3C3C33C;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         line_start;
  logic [8:0]   y_dis;
  logic [9:0]   x_dis;

  logic         rom_rd, pix_in_box, pix_on, fetch_err;
  logic [4:0]   rom_addr;
  logic [127:0] rom_data;

  logic         l_rom_rd, l_pix_in_box, l_pix_on, l_fetch_err;
  logic [4:0]   l_rom_addr;
  logic [127:0] l_rom_data;

  logic [127:0] rom_mem [32];
  logic [127:0] l_pipe [4];

  int n_vec = 0;
  int n_err = 0;

  int rd_cnt, box_cnt, first_x, pop, err_cnt, off_on;
  logic [4:0]   rd_addr;
  logic [127:0] stream;
  int l_box_cnt, l_first_x, l_err_cnt;
  logic [127:0] l_stream;

  always #10 clk = ~clk;

  glyph_row_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .y_dis      (y_dis),
    .x_dis      (x_dis),
    .rom_rd     (rom_rd),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .pix_in_box (pix_in_box),
    .pix_on     (pix_on),
    .fetch_err  (fetch_err)
  );

  glyph_row_fetch #(.X_ORIGIN(2), .ROM_LAT(4)) dut_late (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .y_dis      (y_dis),
    .x_dis      (x_dis),
    .rom_rd     (l_rom_rd),
    .rom_addr   (l_rom_addr),
    .rom_data   (l_rom_data),
    .pix_in_box (l_pix_in_box),
    .pix_on     (l_pix_on),
    .fetch_err  (l_fetch_err)
  );

  // Font ROMs: junk on every cycle except the one the read lands on
  always @(posedge clk) rom_data <= rom_rd ? rom_mem[rom_addr] : JUNK;

  always @(posedge clk) begin
    l_pipe[0] <= l_rom_rd ? rom_mem[l_rom_addr] : JUNK;
    for (int i = 1; i < 4; i++) l_pipe[i] <= l_pipe[i-1];
  end
  assign l_rom_data = l_pipe[3];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    line_start = 1'b0;
    x_dis      = x_dis + 10'd1;
  endtask

  task automatic begin_line(input int y, input int x0);
    line_start = 1'b1;
    y_dis      = 9'(y);
    x_dis      = 10'(x0);
  endtask

  task automatic collect(input int n);
    rd_cnt = 0; rd_addr = '0; box_cnt = 0; first_x = -1; pop = 0;
    err_cnt = 0; off_on = 0; stream = '0;
    l_box_cnt = 0; l_first_x = -1; l_err_cnt = 0; l_stream = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (rom_rd) begin rd_cnt++; rd_addr = rom_addr; end
      if (fetch_err) err_cnt++;
      if (pix_on && !pix_in_box) off_on++;
      if (pix_in_box) begin
        if (box_cnt == 0) first_x = int'(x_dis);
        box_cnt++;
        stream = {stream[126:0], pix_on};
        pop += int'(pix_on);
      end
      if (l_fetch_err) l_err_cnt++;
      if (l_pix_in_box) begin
        if (l_box_cnt == 0) l_first_x = int'(x_dis);
        l_box_cnt++;
        l_stream = {l_stream[126:0], l_pix_on};
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom_mem[i] = {4{32'(i) * 32'h01010101}};
    rom_mem[0]  = TOP_ROW;
    rom_mem[4]  = ONES_ROW;
    rom_mem[5]  = FULL_ROW;
    rom_mem[10] = LATE_ROW;
    rom_mem[31] = LAST_ROW;

    rst_n = 1'b1; line_start = 1'b0; y_dis = '0; x_dis = '0;
    #5 rst_n = 1'b0;
    #5;
    chk("rst_rom_rd",  128'(rom_rd), 128'd0);
    chk("rst_addr",    128'(rom_addr), 128'd0);
    chk("rst_box",     128'(pix_in_box), 128'd0);
    chk("rst_pix_on",  128'(pix_on), 128'd0);
    chk("rst_err",     128'(fetch_err), 128'd0);
    chk("rst_l_err",   128'(l_fetch_err), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Top row: first and last pixels lit
    begin_line(231, 0);
    tick();
    chk("top_rd_next", 128'(rom_rd), 128'd1);
    chk("top_addr", 128'(rom_addr), 128'd0);
    collect(449);
    chk("top_box_len", 128'(box_cnt), 128'd128);
    chk("top_first_x", 128'(first_x), 128'd302);
    chk("top_stream", stream, TOP_ROW);
    chk("top_pop", 128'(pop), 128'd2);
    chk("top_err", 128'(err_cnt), 128'd0);
    chk("top_off_on", 128'(off_on), 128'd0);

    // Lines just outside the box
    begin_line(230, 0);
    collect(450);
    chk("y230_rd", 128'(rd_cnt), 128'd0);
    chk("y230_box", 128'(box_cnt), 128'd0);
    chk("y230_err", 128'(err_cnt), 128'd0);
    begin_line(263, 0);
    collect(450);
    chk("y263_rd", 128'(rd_cnt), 128'd0);
    chk("y263_box", 128'(box_cnt), 128'd0);
    chk("y263_err", 128'(err_cnt), 128'd0);

    // Bottom row of the box
    begin_line(262, 0);
    collect(450);
    chk("y262_rd", 128'(rd_cnt), 128'd1);
    chk("y262_addr", 128'(rd_addr), 128'd31);
    chk("y262_box", 128'(box_cnt), 128'd128);
    chk("y262_stream", stream, LAST_ROW);

    // Dense row; 30 set bits in this pattern
    begin_line(236, 0);
    collect(450);
    chk("full_addr", 128'(rd_addr), 128'd5);
    chk("full_box", 128'(box_cnt), 128'd128);
    chk("full_stream", stream, FULL_ROW);
    chk("full_pop", 128'(pop), 128'(int'($countones(FULL_ROW))));
    chk("full_first_x", 128'(first_x), 128'd302);

    // Early window on the slow-ROM instance
    begin_line(240, 0);
    collect(300);
    chk("late_err", 128'(l_err_cnt), 128'd1);
    chk("late_box", 128'(l_box_cnt), 128'd0);
    // Same instance with enough lead before its window
    begin_line(241, 1020);
    collect(150);
    chk("late2_err", 128'(l_err_cnt), 128'd0);
    chk("late2_box", 128'(l_box_cnt), 128'd128);
    chk("late2_first_x", 128'(l_first_x), 128'd3);
    chk("late2_stream", l_stream, LATE_ROW);

    // line_start arriving at box cycle 40
    begin_line(233, 0);
    collect(341);
    chk("inj_box_before", 128'(box_cnt), 128'd40);
    chk("inj_box_live", 128'(pix_in_box), 128'd1);
    line_start = 1'b1;
    y_dis      = 9'd234;
    tick();
    chk("inj_box_drop", 128'(pix_in_box), 128'd0);
    chk("inj_pix_off", 128'(pix_on), 128'd0);
    chk("inj_rd", 128'(rom_rd), 128'd1);
    chk("inj_addr", 128'(rom_addr), 128'd3);

    // Reset pulse at box cycle 60 on an all-ones row
    begin_line(235, 0);
    collect(361);
    chk("rst60_box_cnt", 128'(box_cnt), 128'd60);
    chk("rst60_pix_pre", 128'(pix_on), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("rst60_box", 128'(pix_in_box), 128'd0);
    chk("rst60_pix", 128'(pix_on), 128'd0);
    chk("rst60_rd", 128'(rom_rd), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    begin_line(235, 0);
    collect(450);
    chk("post_rst_addr", 128'(rd_addr), 128'd4);
    chk("post_rst_box", 128'(box_cnt), 128'd128);
    chk("post_rst_first_x", 128'(first_x), 128'd302);
    chk("post_rst_stream", stream, ONES_ROW);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
